// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared state encoding, default debounce length and button indices.
package button_conditioner_pkg;
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int BTN_DATO1 = 0;
  localparam int BTN_DATO2 = 1;
  localparam int BTN_CODE  = 2;
endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// debounce_cell: two-flop synchronizer plus debounce FSM for one button.
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NB_CNT          = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic press_accept
);
  localparam logic [NB_CNT:0] D_LIM = (NB_CNT+1)'(DEBOUNCE_CYCLES);
  logic              sync1_q, sync2_q, level_q, level_d;
  state_t            state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic [NB_CNT:0]   cnt_inc;
  logic              done;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign done    = cnt_inc >= D_LIM;
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    press_accept = 1'b0;
    case (state_q)
      RELEASED: if (sync2_q) begin
        state_d = PRESS_CHK;
        cnt_d   = NB_CNT'(1);
      end
      PRESS_CHK: if (!sync2_q) begin
        state_d = RELEASED;
        cnt_d   = '0;
      end else if (done) begin
        state_d      = PRESSED;
        cnt_d        = '0;
        press_accept = 1'b1;
      end else cnt_d = cnt_inc[NB_CNT-1:0];
      PRESSED: if (!sync2_q) begin
        state_d = RELEASE_CHK;
        cnt_d   = NB_CNT'(1);
      end
      default: if (sync2_q) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (done) begin
        state_d = RELEASED;
        cnt_d   = '0;
      end else cnt_d = cnt_inc[NB_CNT-1:0];
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes switches, debounces buttons and emits one strobe per accepted press.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NB_IN           = 8,
  parameter int NB_BTN          = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NB_CNT          = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_BTN-1:0] btn_in,
  input  logic [NB_IN-1:0]  switch_in,
  output logic [NB_BTN-1:0] btn_pulse,
  output logic [NB_BTN-1:0] btn_level,
  output logic [NB_IN-1:0]  switch_out,
  output logic              multi_err
);
  logic [NB_IN-1:0]  sw1_q, sw2_q;
  logic [NB_BTN-1:0] accept, pulse_q, pulse_d;
  logic              multi_q, multi_d;
  for (genvar i = 0; i < NB_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .NB_CNT         (NB_CNT)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (btn_in[i]),
      .level       (btn_level[i]),
      .press_accept(accept[i])
    );
  end
  // Simultaneous presses are ambiguous to the loader, so they are flagged instead of strobed.
  always_comb begin
    pulse_d = ($countones(accept) == 1) ? accept : '0;
    multi_d = $countones(accept) > 1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw1_q   <= '0;
      sw2_q   <= '0;
      pulse_q <= '0;
      multi_q <= 1'b0;
    end else begin
      sw1_q   <= switch_in;
      sw2_q   <= sw1_q;
      pulse_q <= pulse_d;
      multi_q <= multi_d;
    end
  end
  assign btn_pulse  = pulse_q;
  assign multi_err  = multi_q;
  assign switch_out = sw2_q;
endmodule
